// File: rtl/pma_region_table_if.sv
// Bundle of the programming (CSR) side and the lookup (frontend/LSU/PTW) side
// of the PMA region table; the table itself connects through the slave modport.
interface pma_region_table_if #(
    parameter int NrRules       = 8,
    parameter int AddrWidth     = 64,
    parameter int NrLookupPorts = 2
);
    localparam int IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

    logic                                         cfg_we_i;
    logic [IdxWidth-1:0]                          cfg_idx_i;
    logic [AddrWidth-1:0]                         cfg_base_i;
    logic [AddrWidth-1:0]                         cfg_len_i;
    logic [2:0]                                   cfg_attr_i;
    logic                                         cfg_lock_i;
    logic                                         cfg_err_o;
    logic                                         flush_o;
    logic [7:0]                                   cfg_gen_o;

    logic [NrLookupPorts-1:0]                     req_valid_i;
    logic [NrLookupPorts-1:0][AddrWidth-1:0]      req_addr_i;
    logic [NrLookupPorts-1:0]                     resp_valid_o;
    logic [NrLookupPorts-1:0]                     resp_hit_o;
    logic [NrLookupPorts-1:0][IdxWidth-1:0]       resp_idx_o;
    logic [NrLookupPorts-1:0][2:0]                resp_attr_o;

    modport master (
        output cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
        output req_valid_i, req_addr_i,
        input  cfg_err_o, flush_o, cfg_gen_o,
        input  resp_valid_o, resp_hit_o, resp_idx_o, resp_attr_o
    );

    modport slave (
        input  cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
        input  req_valid_i, req_addr_i,
        output cfg_err_o, flush_o, cfg_gen_o,
        output resp_valid_o, resp_hit_o, resp_idx_o, resp_attr_o
    );
endinterface

// File: rtl/pma_region_table.sv
// Runtime-programmable physical-memory-attribute table: lockable {X,NI,C}
// regions, lowest-index-wins lookup on several independent ports, one-cycle latency.
module pma_region_table #(
    parameter int         NrRules       = 8,
    parameter int         AddrWidth     = 64,
    parameter int         NrLookupPorts = 2,
    parameter logic [2:0] DefaultAttr   = 3'b010
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pma_region_table_if.slave bus
);
    localparam int IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [2:0]           attr_q [NrRules];
    logic [NrRules-1:0]   lock_q;

    logic       cfg_err_q;
    logic       flush_q;
    logic [7:0] cfg_gen_q;

    logic idx_in_range;
    logic target_locked;
    logic wr_reject;
    logic wr_accept;

    logic [NrLookupPorts-1:0]                 hit_d;
    logic [NrLookupPorts-1:0][IdxWidth-1:0]   idx_d;
    logic [NrLookupPorts-1:0][2:0]            attr_d;

    logic [NrLookupPorts-1:0]                 resp_valid_q;
    logic [NrLookupPorts-1:0]                 resp_hit_q;
    logic [NrLookupPorts-1:0][IdxWidth-1:0]   resp_idx_q;
    logic [NrLookupPorts-1:0][2:0]            resp_attr_q;

    assign idx_in_range = 32'(bus.cfg_idx_i) < NrRules;

    always_comb begin
        target_locked = 1'b0;
        for (int i = 0; i < NrRules; i++) begin
            if (bus.cfg_idx_i == IdxWidth'(i)) begin
                target_locked = lock_q[i];
            end
        end
    end

    assign wr_reject = bus.cfg_we_i && (!idx_in_range || target_locked);
    assign wr_accept = bus.cfg_we_i && idx_in_range && !target_locked;

    // Lock bits are sticky: only reset clears them, a write can only add one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrRules; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                attr_q[i] <= '0;
            end
            lock_q    <= '0;
            cfg_err_q <= 1'b0;
            flush_q   <= 1'b0;
            cfg_gen_q <= '0;
        end else begin
            cfg_err_q <= wr_reject;
            flush_q   <= wr_accept;
            if (wr_accept) begin
                cfg_gen_q <= cfg_gen_q + 8'd1;
                for (int i = 0; i < NrRules; i++) begin
                    if (bus.cfg_idx_i == IdxWidth'(i)) begin
                        base_q[i] <= bus.cfg_base_i;
                        len_q[i]  <= bus.cfg_len_i;
                        attr_q[i] <= bus.cfg_attr_i;
                        lock_q[i] <= lock_q[i] | bus.cfg_lock_i;
                    end
                end
            end
        end
    end

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    // The extra MSB keeps regions that run past the top of memory from wrapping to 0.
    always_comb begin
        hit_d  = '0;
        idx_d  = '0;
        attr_d = {NrLookupPorts{DefaultAttr}};
        for (int p = 0; p < NrLookupPorts; p++) begin
            for (int i = NrRules - 1; i >= 0; i--) begin
                if ((len_q[i] != '0) &&
                    ({1'b0, bus.req_addr_i[p]} >= {1'b0, base_q[i]}) &&
                    (({1'b0, bus.req_addr_i[p]} - {1'b0, base_q[i]}) < {1'b0, len_q[i]})) begin
                    hit_d[p]  = 1'b1;
                    idx_d[p]  = IdxWidth'(i);
                    attr_d[p] = attr_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= '0;
            resp_hit_q   <= '0;
            resp_idx_q   <= '0;
            resp_attr_q  <= {NrLookupPorts{DefaultAttr}};
        end else begin
            resp_valid_q <= bus.req_valid_i;
            for (int p = 0; p < NrLookupPorts; p++) begin
                if (bus.req_valid_i[p]) begin
                    resp_hit_q[p]  <= hit_d[p];
                    resp_idx_q[p]  <= idx_d[p];
                    resp_attr_q[p] <= attr_d[p];
                end
            end
        end
    end

    assign bus.cfg_err_o    = cfg_err_q;
    assign bus.flush_o      = flush_q;
    assign bus.cfg_gen_o    = cfg_gen_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_hit_o   = resp_hit_q;
    assign bus.resp_idx_o   = resp_idx_q;
    assign bus.resp_attr_o  = resp_attr_q;
endmodule
